// File: rtl/camera_cmd_sequencer.sv
// camera_cmd_sequencer: queues key presses and issues one camera command per rendered frame
// Ports: key_press/key_release pulses in; cmd_valid/cmd_ready handshake carrying cmd_key/cmd_rot/cmd_hold;
// render_frame/rendering_done pace frames; held is the held-key bitmap; drop flags a lost press.
// rst is asynchronous and active-low.
module camera_cmd_sequencer #(
    parameter int                  NUM_KEYS   = 12,
    parameter int                  FIFO_DEPTH = 4,
    parameter int                  CNT_W      = 16,
    parameter logic [NUM_KEYS-1:0] ROT_MASK   = 12'hFC0,
    parameter bit                  ROT_REPEAT = 1'b0,
    localparam int                 KEY_W      = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_press,
    input  logic [NUM_KEYS-1:0] key_release,
    input  logic                cmd_ready,
    input  logic                rendering_done,
    output logic                cmd_valid,
    output logic [KEY_W-1:0]    cmd_key,
    output logic                cmd_rot,
    output logic [CNT_W-1:0]    cmd_hold,
    output logic                render_frame,
    output logic [NUM_KEYS-1:0] held,
    output logic                drop
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nx;
    logic [KEY_W-1:0] fifo [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic [KEY_W-1:0] push_key, head, cur_key, issue_key;
    logic [CNT_W-1:0] hc;
    logic empty, full, any_press, multi, push, pop, cur_valid, rep_ok, start;
    always_comb begin
        push_key = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (key_press[i]) push_key = KEY_W'(i);
    end
    // extra pointer bit distinguishes full from empty
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign any_press = |key_press;
    assign multi     = |(key_press & (key_press - NUM_KEYS'(1)));
    assign head      = fifo[rd_ptr[PTR_W-1:0]];
    assign pop       = (state == IDLE) && !empty;
    assign push      = any_press && (!full || pop);
    assign rep_ok    = held[cur_key] && cur_valid && (!ROT_MASK[cur_key] || ROT_REPEAT);
    // queued presses win over repeats
    assign start     = (state == IDLE) && (!empty || rep_ok);
    assign issue_key = pop ? head : cur_key;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE  ? (start ? ISSUE : IDLE) :
                   state == ISSUE ? (cmd_ready ? WAIT : ISSUE) :
                                    (rendering_done ? IDLE : WAIT);
    end
    always_comb begin
        cmd_valid    = state == ISSUE;
        render_frame = (state == ISSUE) && cmd_ready;
    end
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[PTR_W-1:0]] <= push_key;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            held      <= '0;
            drop      <= 1'b0;
            cur_key   <= '0;
            cur_valid <= 1'b0;
            hc        <= '0;
            cmd_key   <= '0;
            cmd_rot   <= 1'b0;
            cmd_hold  <= '0;
        end else begin
            held <= (held | key_press) & ~key_release;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (multi || (any_press && full && !pop)) drop <= 1'b1;
            if (pop) begin
                cur_key   <= head;
                cur_valid <= 1'b1;
            end
            if (pop) hc <= '0;
            else if (held[cur_key] && hc != '1) hc <= hc + 1'b1;
            if (start) begin
                cmd_key  <= issue_key;
                cmd_rot  <= ROT_MASK[issue_key];
                cmd_hold <= pop ? '0 : hc;
            end
        end
    end
endmodule

// File: tb/tb_camera_cmd_sequencer.sv
// tb_camera_cmd_sequencer: directed bench with a command scoreboard for camera_cmd_sequencer
module tb_camera_cmd_sequencer;
    typedef struct packed {
        logic [3:0]  key;
        logic        rot;
        logic [15:0] hold;
    } cmd_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [11:0] key_press = '0, key_release = '0;
    logic cmd_ready = 1'b1;
    logic rd_auto = 1'b0, rd_man = 1'b0;
    logic rendering_done;
    logic cmd_valid, cmd_rot, render_frame, drop;
    logic [3:0] cmd_key;
    logic [15:0] cmd_hold;
    logic [11:0] held;
    logic cmd_valid1, cmd_rot1, render_frame1, drop1;
    logic [3:0] cmd_key1;
    logic [15:0] cmd_hold1;
    logic [11:0] held1;
    bit auto_done = 1'b1;
    bit mon1_en = 1'b0;
    int checks = 0, failures = 0, rf_cnt = 0, rf_base;
    cmd_t q0[$], q1[$];
    assign rendering_done = rd_auto | rd_man;
    always #5 clk = ~clk;
    camera_cmd_sequencer dut (
        .clk(clk), .rst(rst), .key_press(key_press), .key_release(key_release),
        .cmd_ready(cmd_ready), .rendering_done(rendering_done), .cmd_valid(cmd_valid),
        .cmd_key(cmd_key), .cmd_rot(cmd_rot), .cmd_hold(cmd_hold),
        .render_frame(render_frame), .held(held), .drop(drop)
    );
    camera_cmd_sequencer #(.ROT_REPEAT(1'b1)) dut_rep (
        .clk(clk), .rst(rst), .key_press(key_press), .key_release(key_release),
        .cmd_ready(cmd_ready), .rendering_done(rendering_done), .cmd_valid(cmd_valid1),
        .cmd_key(cmd_key1), .cmd_rot(cmd_rot1), .cmd_hold(cmd_hold1),
        .render_frame(render_frame1), .held(held1), .drop(drop1)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic cmd_t mk(input int k, input int r, input int h);
        mk = {4'(k), 1'(r), 16'(h)};
    endfunction
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic tap(input int k);
        key_press[k] = 1'b1;
        key_release[k] = 1'b1;
        tick();
        key_press = '0;
        key_release = '0;
    endtask
    task automatic do_reset();
        rst = 1'b0;
        key_press = '0;
        key_release = '0;
        cmd_ready = 1'b1;
        rd_man = 1'b0;
        auto_done = 1'b1;
        mon1_en = 1'b0;
        q0.delete();
        q1.delete();
        tick(3);
        rst = 1'b1;
        tick();
    endtask
    // frame renderer model: finishes 10 cycles after each frame start
    always begin
        @(negedge clk);
        if (auto_done && (render_frame || render_frame1)) begin
            repeat (10) @(posedge clk);
            #2 rd_auto = 1'b1;
            @(posedge clk);
            #2 rd_auto = 1'b0;
        end
    end
    always @(negedge clk) begin
        if (render_frame) rf_cnt++;
        if (rst && cmd_valid && cmd_ready) begin
            chk("cmd0_expected", q0.size() > 0, 1);
            if (q0.size() > 0) chk("cmd0", {cmd_key, cmd_rot, cmd_hold}, q0.pop_front());
        end
        if (rst && mon1_en && cmd_valid1 && cmd_ready) begin
            chk("cmd1_expected", q1.size() > 0, 1);
            if (q1.size() > 0) chk("cmd1", {cmd_key1, cmd_rot1, cmd_hold1}, q1.pop_front());
        end
    end
    initial begin
        tick(2);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_rf", render_frame, 0);
        chk("rst_drop", drop, 0);
        chk("rst_held", held, 0);
        chk("rst_key", cmd_key, 0);
        chk("rst_rot", cmd_rot, 0);
        chk("rst_hold", cmd_hold, 0);
        do_reset();
        // tap of key 4
        q0.push_back(mk(4, 0, 0));
        tap(4);
        chk("tap_valid_early", cmd_valid, 0);
        chk("tap_held", held[4], 0);
        tick();
        chk("tap_valid", cmd_valid, 1);
        chk("tap_rf", render_frame, 1);
        tick(30);
        chk("tap_pending", q0.size(), 0);
        // held translate key 0 for 40 cycles
        do_reset();
        q0.push_back(mk(0, 0, 0));
        q0.push_back(mk(0, 0, 11));
        q0.push_back(mk(0, 0, 23));
        q0.push_back(mk(0, 0, 35));
        key_press[0] = 1'b1;
        tick();
        key_press = '0;
        chk("hold_held", held[0], 1);
        tick(39);
        key_release[0] = 1'b1;
        tick();
        key_release = '0;
        chk("hold_released", held[0], 0);
        tick(40);
        chk("hold_pending", q0.size(), 0);
        // rotation key 6 held 50 cycles, with and without repeat
        do_reset();
        mon1_en = 1'b1;
        q0.push_back(mk(6, 1, 0));
        q1.push_back(mk(6, 1, 0));
        q1.push_back(mk(6, 1, 11));
        q1.push_back(mk(6, 1, 23));
        q1.push_back(mk(6, 1, 35));
        q1.push_back(mk(6, 1, 47));
        key_press[6] = 1'b1;
        tick();
        key_press = '0;
        tick(49);
        key_release[6] = 1'b1;
        tick();
        key_release = '0;
        tick(40);
        chk("rot_pending0", q0.size(), 0);
        chk("rot_pending1", q1.size(), 0);
        mon1_en = 1'b0;
        // overflow while stalled in WAIT
        do_reset();
        auto_done = 1'b0;
        q0.push_back(mk(8, 1, 0));
        tap(8);
        tick(2);
        chk("ovf_drop_before", drop, 0);
        for (int k = 0; k < 6; k++) tap(k);
        for (int k = 0; k < 4; k++) q0.push_back(mk(k, 0, 0));
        chk("ovf_drop", drop, 1);
        chk("ovf_stalled", cmd_valid, 0);
        auto_done = 1'b1;
        rd_man = 1'b1;
        tick();
        rd_man = 1'b0;
        tick(80);
        chk("ovf_pending", q0.size(), 0);
        // simultaneous presses of keys 2 and 3
        do_reset();
        q0.push_back(mk(2, 0, 0));
        key_press = 12'b1100;
        key_release = 12'b1100;
        tick();
        key_press = '0;
        key_release = '0;
        chk("multi_drop", drop, 1);
        tick(30);
        chk("multi_pending", q0.size(), 0);
        // backpressure: 20 stalled cycles with key 2 held
        do_reset();
        cmd_ready = 1'b0;
        q0.push_back(mk(2, 0, 0));
        key_press[2] = 1'b1;
        tick();
        key_press = '0;
        tick();
        rf_base = rf_cnt;
        for (int c = 0; c < 20; c++) begin
            chk("bp_valid", cmd_valid, 1);
            chk("bp_key", cmd_key, 2);
            chk("bp_hold", cmd_hold, 0);
            chk("bp_rf", render_frame, 0);
            tick();
        end
        cmd_ready = 1'b1;
        #1;
        chk("bp_rf_ready", render_frame, 1);
        key_release[2] = 1'b1;
        tick();
        key_release = '0;
        chk("bp_rf_after", render_frame, 0);
        chk("bp_valid_after", cmd_valid, 0);
        tick(30);
        chk("bp_rf_count", rf_cnt - rf_base, 1);
        chk("bp_pending", q0.size(), 0);
        // reset while in WAIT with two queued presses
        do_reset();
        auto_done = 1'b0;
        q0.push_back(mk(7, 1, 0));
        key_press[7] = 1'b1;
        tick();
        key_press = '0;
        tick(2);
        key_press = 12'b0011;
        tick();
        key_press = '0;
        tap(2);
        chk("mid_key", cmd_key, 7);
        chk("mid_drop", drop, 1);
        chk("mid_held", held, 12'h083);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_rf", render_frame, 0);
        chk("mid_rst_drop", drop, 0);
        chk("mid_rst_held", held, 0);
        chk("mid_rst_key", cmd_key, 0);
        chk("mid_rst_rot", cmd_rot, 0);
        chk("mid_rst_hold", cmd_hold, 0);
        q0.delete();
        tick(2);
        rst = 1'b1;
        tick();
        rd_man = 1'b1;
        tick();
        rd_man = 1'b0;
        tick(20);
        chk("post_rst_valid", cmd_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
